// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults and state type for the FIFO read-side packer
package fifo_pkg;
   localparam int DATA_WIDTH_DEF = 8;
   localparam int PACK_DEF = 4;
   typedef enum logic {FILL, FLUSH} state_t;
endpackage

// File: rtl/fifo_out_slot.sv
// fifo_out_slot: single-entry output holding register with valid/ready handshake
module fifo_out_slot #(
   parameter int W = 32,
   parameter int K = 4
) (
   input  logic         clk_rd,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_data,
   input  logic [K-1:0] load_keep,
   input  logic         ready,
   output logic         valid,
   output logic [W-1:0] data,
   output logic [K-1:0] keep
);
   always_ff @(posedge clk_rd) begin
      if (rst) begin
         valid <= 1'b0;
         data  <= '0;
         keep  <= '0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= load_data;
         keep  <= load_keep;
      end else if (ready) begin
         valid <= 1'b0;
      end
   end
endmodule

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: packs show-ahead FIFO entries into PACK-lane words, with flush of partial words
module fifo_rd_packer
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int PACK = PACK_DEF
) (
   input  logic                       clk_rd,
   input  logic                       rst,
   input  logic [DATA_WIDTH-1:0]      fifo_rd_data,
   input  logic                       fifo_empty,
   output logic                       fifo_rd_en,
   input  logic                       flush,
   output logic [DATA_WIDTH*PACK-1:0] out_data,
   output logic [PACK-1:0]            out_keep,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [$clog2(PACK):0]      lane_cnt
);
   localparam int LW = $clog2(PACK) + 1;
   state_t state, state_n;
   logic [DATA_WIDTH*PACK-1:0] asm_q, asm_n;
   logic [LW-1:0] fill_cnt;
   logic [PACK-1:0] keep_n;
   logic last, slot_free, load;
   assign last = lane_cnt == LW'(PACK - 1);
   assign fifo_rd_en = !rst && !fifo_empty && state == FILL && !(last && out_valid && !out_ready);
   assign slot_free = !out_valid || out_ready;
   // pops only happen in FILL, so a full-word load and a partial load never coincide
   assign load = (fifo_rd_en && last) || (state == FLUSH && lane_cnt != '0 && slot_free);
   assign fill_cnt = lane_cnt + LW'(fifo_rd_en);
   always_comb begin
      asm_n = asm_q;
      keep_n = '0;
      for (int i = 0; i < PACK; i++) begin
         if (fifo_rd_en && lane_cnt == LW'(i)) asm_n[i*DATA_WIDTH +: DATA_WIDTH] = fifo_rd_data;
         keep_n[i] = LW'(i) < fill_cnt;
      end
      state_n = (state == FILL) ? (flush ? FLUSH : FILL) : ((lane_cnt == '0 || load) ? FILL : FLUSH);
   end
   always_ff @(posedge clk_rd) begin
      if (rst) begin
         state    <= FILL;
         lane_cnt <= '0;
         asm_q    <= '0;
      end else begin
         state    <= state_n;
         lane_cnt <= load ? '0 : fill_cnt;
         asm_q    <= load ? '0 : asm_n;
      end
   end
   fifo_out_slot #(.W(DATA_WIDTH*PACK), .K(PACK)) u_slot (
      .clk_rd   (clk_rd),
      .rst      (rst),
      .load     (load),
      .load_data(asm_n),
      .load_keep(keep_n),
      .ready    (out_ready),
      .valid    (out_valid),
      .data     (out_data),
      .keep     (out_keep)
   );
endmodule
